// File: rtl/regdump_pkg.sv
// Shared types for the register-file dump client.
// Holds the FSM state enum and the last-index helper.
package regdump_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
    S_SUM  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic int last_idx(input int regbits);
    return (1 << regbits) - 1;
  endfunction

endpackage

// File: rtl/regfile_dump.sv
// Walks every regfile address on a spare read port and streams the
// captured values out as valid/ready beats (addr, data, last).
// Ports: clk, reset_n (async, active-low), start, abort,
//   dump_ra/dump_rd (regfile read port), out_valid/out_ready,
//   out_data, out_addr, out_last, busy, done.
// Build option REGDUMP_CHECKSUM_EN appends a checksum beat.
module regfile_dump
  import regdump_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  output logic [REGBITS-1:0] dump_ra,
  input  logic [WIDTH-1:0]   dump_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [REGBITS-1:0] out_addr,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  // One spare bit so the last-compare never wraps.
  localparam logic [REGBITS:0] LAST =
    (REGBITS+1)'(last_idx(REGBITS));

  state_t             state;
  state_t             state_nx;
  logic [REGBITS:0]   idx;
  logic [REGBITS:0]   idx_nx;
  logic [WIDTH-1:0]   data_q;
  logic               is_last;
  logic               hs;

`ifdef REGDUMP_CHECKSUM_EN
  logic [WIDTH-1:0]   csum;
`endif

  assign is_last = (idx == LAST);
  assign hs      = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      idx_nx   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          // abort beats start in IDLE
          if (start && !abort) begin
            state_nx = S_READ;
            idx_nx   = '0;
          end
        end
        S_READ: state_nx = S_SEND;
        S_SEND: begin
          if (hs) begin
            if (is_last) begin
`ifdef REGDUMP_CHECKSUM_EN
              state_nx = S_SUM;
`else
              state_nx = S_DONE;
`endif
            end else begin
              idx_nx   = idx + 1'b1;
              state_nx = S_READ;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        S_SUM: begin
          if (hs) state_nx = S_DONE;
        end
`endif
        S_DONE: begin
          state_nx = S_IDLE;
          idx_nx   = '0;
        end
        default: begin
          state_nx = S_IDLE;
          idx_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (state == S_READ) data_q <= dump_rd;
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum <= '0;
    end else if (state == S_IDLE && state_nx == S_READ) begin
      csum <= '0;
    end else if (state == S_SEND && hs && !abort) begin
      csum <= csum + data_q;
    end
  end
`endif

  assign dump_ra  = (state == S_READ) ? idx[REGBITS-1:0] : '0;
  assign out_addr = (state == S_SEND) ? idx[REGBITS-1:0] : '0;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

`ifdef REGDUMP_CHECKSUM_EN
  assign out_valid = (state == S_SEND) || (state == S_SUM);
  assign out_data  = (state == S_SUM) ? csum : data_q;
  assign out_last  = (state == S_SUM);
`else
  assign out_valid = (state == S_SEND);
  assign out_data  = data_q;
  assign out_last  = (state == S_SEND) && is_last;
`endif

endmodule
